cp0_unit: RTL

- Coprocessor-0 block directly downstream of the timer.
- Consumes the timer IRQ lines and other device IRQ lines on HWInt[7:2], plus the pipeline's synchronous exception code.
- Decides whether to take an interrupt or exception, and holds SR, Cause, EPC and PRId.
- Gives the pipeline the flush/redirect request and the EPC used by eret.

---
 rtl/cp0_unit_pkg.sv | 21 ++
 rtl/cp0_int_arbiter.sv | 21 ++
 rtl/cp0_unit.sv | 78 +++++++
 3 files changed

// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: CP0 register numbers, SR/Cause field positions and exception codes
package cp0_unit_pkg;
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int IM_LSB    = 10;
  localparam int IP_LSB    = 10;
  localparam int CAUSE_BD  = 31;
  localparam int EXC_LSB   = 2;
  localparam logic [31:0] PRID_DEFAULT = 32'h0000_5037;
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;
endpackage

// File: rtl/cp0_int_arbiter.sv
// cp0_int_arbiter: decides interrupt vs exception; interrupts beat a same-cycle sync exception
module cp0_int_arbiter import cp0_unit_pkg::*; #(
  parameter int EXC_CODE_W = 5
) (
  input  logic [5:0]            hw_int,
  input  logic [5:0]            im,
  input  logic                  ie,
  input  logic                  exl,
  input  logic [EXC_CODE_W-1:0] exc_code_in,
  output logic                  int_req,
  output logic                  exc_req,
  output logic                  req,
  output logic [EXC_CODE_W-1:0] exc_code_nxt
);
  always_comb begin
    int_req      = |(hw_int & im) & ie & ~exl;
    exc_req      = (exc_code_in != '0) & ~exl;
    req          = int_req | exc_req;
    exc_code_nxt = int_req ? EXC_CODE_W'(EXC_INT) : exc_code_in;
  end
endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 holding SR/Cause/EPC/PRId and raising the pipeline flush request
module cp0_unit import cp0_unit_pkg::*; #(
  parameter logic [31:0] PRID_VALUE = PRID_DEFAULT,
  parameter int          EXC_CODE_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4:0]            A1,
  input  logic [4:0]            A2,
  input  logic [31:0]           DIn,
  input  logic                  We,
  input  logic [31:0]           PC,
  input  logic                  BD,
  input  logic [EXC_CODE_W-1:0] ExcCodeIn,
  input  logic                  EXLClr,
  input  logic [5:0]            HWInt,
  output logic                  Req,
  output logic [31:0]           EPCOut,
  output logic [31:0]           DOut
);
  logic [5:0]            im, ip;
  logic                  exl, ie, bd;
  logic [EXC_CODE_W-1:0] exc_code, exc_code_nxt;
  logic [29:0]           epc;
  logic                  int_req, exc_req;
  logic [31:0]           sr, cause;
  logic [1:0]            unused_pc;

  cp0_int_arbiter #(.EXC_CODE_W(EXC_CODE_W)) u_arb (
    .hw_int(HWInt), .im(im), .ie(ie), .exl(exl), .exc_code_in(ExcCodeIn),
    .int_req(int_req), .exc_req(exc_req), .req(Req), .exc_code_nxt(exc_code_nxt)
  );

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      im       <= '0;
      ip       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        exl      <= 1'b1;
        epc      <= BD ? PC[31:2] - 30'd1 : PC[31:2];
        bd       <= BD;
        exc_code <= exc_code_nxt;
      end else begin
        if (We && A2 == REG_SR) begin
          im  <= DIn[IM_LSB +: 6];
          exl <= DIn[SR_EXL];
          ie  <= DIn[SR_IE];
        end
        if (We && A2 == REG_EPC) epc <= DIn[31:2];
        // eret clears EXL after any same-cycle SR write
        if (EXLClr) exl <= 1'b0;
      end
    end

  always_comb begin
    sr        = 32'b0;
    sr[IM_LSB +: 6] = im;
    sr[SR_EXL]      = exl;
    sr[SR_IE]       = ie;
    cause     = 32'b0;
    cause[CAUSE_BD]          = bd;
    cause[IP_LSB +: 6]       = ip;
    cause[EXC_LSB +: EXC_CODE_W] = exc_code;
    EPCOut    = {epc, 2'b00};
    unused_pc = {PC[1:0]} ^ {exc_req, 1'b0};
    DOut      = A1 == REG_SR    ? sr :
                A1 == REG_CAUSE ? cause :
                A1 == REG_EPC   ? EPCOut :
                A1 == REG_PRID  ? PRID_VALUE : 32'b0;
  end
endmodule
